fence_sequencer: RTL

//  Sequences the multi-cycle memory-ordering side effects of committed FENCE, FENCE.I and

---
 rtl/fence_sequencer_if.sv | 31 +++
 rtl/fence_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fence_sequencer_if.sv
// fence_sequencer_if
//   Bundles the trap-path request, memory-subsystem status and sequencer
//   output strobes of fence_sequencer.
//   slave  : the sequencer side (consumes IN_*, drives OUT_*)
//   master : the environment side (drives IN_*, observes OUT_*)
interface fence_sequencer_if;
    logic       IN_fenceReq;
    logic [1:0] IN_fenceKind;
    logic       IN_sqEmpty;
    logic       IN_MEM_busy;
    logic       OUT_memFence;
    logic       OUT_clearICache;
    logic       OUT_flushTLB;
    logic       OUT_disableIFetch;
    logic       OUT_busy;
    logic       OUT_done;
    logic       OUT_overlapErr;
    logic       OUT_timeout;

    modport slave (
        input  IN_fenceReq, IN_fenceKind, IN_sqEmpty, IN_MEM_busy,
        output OUT_memFence, OUT_clearICache, OUT_flushTLB, OUT_disableIFetch,
               OUT_busy, OUT_done, OUT_overlapErr, OUT_timeout
    );

    modport master (
        output IN_fenceReq, IN_fenceKind, IN_sqEmpty, IN_MEM_busy,
        input  OUT_memFence, OUT_clearICache, OUT_flushTLB, OUT_disableIFetch,
               OUT_busy, OUT_done, OUT_overlapErr, OUT_timeout
    );
endinterface

// File: rtl/fence_sequencer.sv
// fence_sequencer
//   Sequences the side effects of committed FENCE / FENCE.I / SFENCE.VMA:
//   drain store queue, memory fence pulse, wait for memory idle, then ICache
//   invalidate or TLB flush, then a one-cycle done pulse. Fetch is disabled
//   for the whole sequence.
// Ports
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : fence_sequencer_if.slave
//          IN_fenceReq/IN_fenceKind  request pulse and kind (3 treated as FENCE)
//          IN_sqEmpty, IN_MEM_busy   wait conditions
//          OUT_memFence, OUT_clearICache, OUT_flushTLB  side-effect strobes
//          OUT_disableIFetch, OUT_busy, OUT_done        sequence status
//          OUT_overlapErr            request dropped while busy (next cycle)
//          OUT_timeout               sticky wait-state timeout flag
module fence_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES      = 1024,
    parameter int unsigned ICACHE_FLUSH_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    fence_sequencer_if.slave   bus
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IC_W = (ICACHE_FLUSH_CYCLES > 1) ? $clog2(ICACHE_FLUSH_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IC_W-1:0] IC_LOAD = IC_W'(ICACHE_FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, DRAIN_SQ, MEM_FENCE, WAIT_MEM, INV_IC, TLB, DONE
    } state_t;

    typedef enum logic [1:0] {
        K_FENCE, K_FENCEI, K_SFENCE
    } kind_t;

    state_t          state, stateNext;
    kind_t           kindQ, kindNext;
    logic [TO_W-1:0] toCnt, toCntNext;
    logic [IC_W-1:0] icCnt, icCntNext;
    logic            timeoutQ, timeoutNext;
    logic            overlapQ, overlapNext;
    logic            toHit;
    logic            waitEntry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            kindQ    <= K_FENCE;
            toCnt    <= '0;
            icCnt    <= '0;
            timeoutQ <= 1'b0;
            overlapQ <= 1'b0;
        end else begin
            state    <= stateNext;
            kindQ    <= kindNext;
            toCnt    <= toCntNext;
            icCnt    <= icCntNext;
            timeoutQ <= timeoutNext;
            overlapQ <= overlapNext;
        end
    end

    // The counter reaches TIMEOUT_CYCLES on the edge that ends this cycle,
    // so the exit is taken here rather than one cycle later.
    assign toHit     = (toCnt >= TO_LAST);
    // Counter is zeroed on entry, so zero marks the WAIT_MEM entry cycle.
    assign waitEntry = (toCnt == '0);

    always_comb begin
        stateNext   = state;
        kindNext    = kindQ;
        toCntNext   = (toCnt != TO_MAX) ? toCnt + TO_W'(1) : toCnt;
        icCntNext   = icCnt;
        timeoutNext = timeoutQ;
        overlapNext = bus.IN_fenceReq && (state != IDLE);

        case (state)
            IDLE: begin
                if (bus.IN_fenceReq) begin
                    case (bus.IN_fenceKind)
                        2'd1:    kindNext = K_FENCEI;
                        2'd2:    kindNext = K_SFENCE;
                        default: kindNext = K_FENCE;
                    endcase
                    stateNext = DRAIN_SQ;
                    toCntNext = '0;
                end
            end
            DRAIN_SQ: begin
                if (bus.IN_sqEmpty || toHit) begin
                    if (!bus.IN_sqEmpty) timeoutNext = 1'b1;
                    if (kindQ == K_SFENCE) begin
                        stateNext = WAIT_MEM;
                        toCntNext = '0;
                    end else begin
                        stateNext = MEM_FENCE;
                    end
                end
            end
            MEM_FENCE: begin
                stateNext = WAIT_MEM;
                toCntNext = '0;
            end
            WAIT_MEM: begin
                if (!waitEntry && (!bus.IN_MEM_busy || toHit)) begin
                    if (bus.IN_MEM_busy) timeoutNext = 1'b1;
                    case (kindQ)
                        K_FENCEI: begin
                            stateNext = INV_IC;
                            icCntNext = IC_LOAD;
                        end
                        K_SFENCE: stateNext = TLB;
                        default:  stateNext = DONE;
                    endcase
                end
            end
            INV_IC: begin
                if (icCnt == '0) stateNext = DONE;
                else             icCntNext = icCnt - IC_W'(1);
            end
            TLB:     stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign bus.OUT_memFence      = (state == MEM_FENCE);
    assign bus.OUT_clearICache   = (state == INV_IC);
    assign bus.OUT_flushTLB      = (state == TLB);
    assign bus.OUT_busy          = (state != IDLE);
    assign bus.OUT_disableIFetch = (state != IDLE);
    assign bus.OUT_done          = (state == DONE);
    assign bus.OUT_overlapErr    = overlapQ;
    assign bus.OUT_timeout       = timeoutQ;
endmodule
